// File: rtl/data_memory_pkg.sv
// Shared types and constants for the load/store data memory.
package data_memory_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // One captured load/store request
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              size;
    logic              isStore;
  } req_t;

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the load/store path and the data memory.
interface data_memory_if
  import data_memory_pkg::*;
();

  logic [DATA_W-1:0] PC_in;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataSw;
  logic              memRead;
  logic              memWrite;
  logic              storeSize;
  logic              cacheMiss;
  logic              fromLSQ;
  logic [DATA_W-1:0] lwData;
  logic [DATA_W-1:0] PC_out;

  modport master (
    output PC_in, address, dataSw, memRead, memWrite, storeSize, cacheMiss, fromLSQ,
    input  lwData, PC_out
  );

  modport slave (
    input  PC_in, address, dataSw, memRead, memWrite, storeSize, cacheMiss, fromLSQ,
    output lwData, PC_out
  );

endinterface

// File: rtl/data_mem_array.sv
// Little-endian byte array: asynchronous 32-bit word read, byte/word write,
// full clear on reset. Byte indices wrap modulo MEM_BYTES.
module data_mem_array
  import data_memory_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdWord,
  input  logic              wrEn,
  input  logic              wrSize,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  logic [7:0] mem_r [MEM_BYTES];

  function automatic logic [IDX_W-1:0] byteIdx(input logic [ADDR_W-1:0] a,
                                               input logic [1:0]        off);
    return IDX_W'(a + {30'd0, off});
  endfunction

  assign rdWord = {mem_r[byteIdx(rdAddr, 2'd3)], mem_r[byteIdx(rdAddr, 2'd2)],
                   mem_r[byteIdx(rdAddr, 2'd1)], mem_r[byteIdx(rdAddr, 2'd0)]};

  // Storage update: clear on reset, otherwise byte or word write
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wrEn) begin
      mem_r[byteIdx(wrAddr, 2'd0)] <= wrData[7:0];
      if (wrSize == SZ_WORD) begin
        mem_r[byteIdx(wrAddr, 2'd1)] <= wrData[15:8];
        mem_r[byteIdx(wrAddr, 2'd2)] <= wrData[23:16];
        mem_r[byteIdx(wrAddr, 2'd3)] <= wrData[31:24];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Data memory front end: accepts one load/store per request, optionally
// stalls for a miss penalty, and returns registered load data tagged by PC.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_BYTES    = 1024,
  parameter int MISS_PENALTY = 1
) (
  input logic          clk,
  input logic          rstn,
  data_memory_if.slave bus
);

  localparam int   CNT_W    = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY + 1) : 1;
  localparam logic HAS_MISS = (MISS_PENALTY > 0) ? 1'b1 : 1'b0;

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  req_t              cap_r;
  logic [DATA_W-1:0] lwData_r;
  logic [DATA_W-1:0] pcOut_r;

  req_t              inReq_s;
  req_t              acc_s;
  logic              request_s;
  logic              missPath_s;
  logic              complete_s;
  logic              wrEn_s;
  logic [DATA_W-1:0] rdWord_s;

  assign inReq_s = '{pc: bus.PC_in, addr: bus.address, data: bus.dataSw,
                     size: bus.storeSize, isStore: bus.memWrite};
  assign request_s  = bus.memRead | bus.memWrite;
  assign missPath_s = bus.cacheMiss & ~bus.fromLSQ & HAS_MISS;

  // Pick the access that completes this edge: live inputs when idle, captured when waiting
  always_comb begin
    acc_s      = inReq_s;
    complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        acc_s      = inReq_s;
        complete_s = request_s & ~missPath_s;
      end
      WAIT: begin
        acc_s      = cap_r;
        complete_s = (cnt_r == CNT_W'(1));
      end
      default: begin
        acc_s      = inReq_s;
        complete_s = 1'b0;
      end
    endcase
    wrEn_s = complete_s & acc_s.isStore;
  end

  data_mem_array #(
    .MEM_BYTES(MEM_BYTES)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .rdAddr(acc_s.addr),
    .rdWord(rdWord_s),
    .wrEn  (wrEn_s),
    .wrSize(acc_s.size),
    .wrAddr(acc_s.addr),
    .wrData(acc_s.data)
  );

  // Control FSM, capture registers and registered outputs
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      cap_r    <= '0;
      lwData_r <= 32'h0000_0000;
      pcOut_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (request_s && missPath_s) begin
            cap_r   <= inReq_s;
            cnt_r   <= CNT_W'(MISS_PENALTY);
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == CNT_W'(1)) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
      if (complete_s) begin
        pcOut_r <= acc_s.pc;
        if (!acc_s.isStore) begin
          lwData_r <= rdWord_s;
        end
      end
    end
  end

  assign bus.lwData = lwData_r;
  assign bus.PC_out = pcOut_r;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (MEM_BYTES=1024, MISS_PENALTY=1).
module tb_data_memory;
  import data_memory_pkg::*;

  logic clk;
  logic rstn;
  int   nChecks;
  int   nPass;

  data_memory_if bus ();

  data_memory #(
    .MEM_BYTES   (1024),
    .MISS_PENALTY(1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                       input logic rd, input logic wr, input logic sz,
                       input logic miss, input logic lsq);
    bus.PC_in     = pc;
    bus.address   = addr;
    bus.dataSw    = data;
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.storeSize = sz;
    bus.cacheMiss = miss;
    bus.fromLSQ   = lsq;
  endtask

  task automatic idle();
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  // Single fast-path access: one edge, then drop the request
  task automatic fastOp(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                        input logic rd, input logic wr, input logic sz);
    drive(pc, addr, data, rd, wr, sz, 1'b0, 1'b0);
    tick(1);
    idle();
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rstn    = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0, 1'b0);
    tick(3);
    checkVal("reset_lw", bus.lwData, 32'h0000_0000);
    checkVal("reset_pc", bus.PC_out, 32'h0000_0000);
    rstn = 1'b0;
    tick(1);

    // Miss store: nothing visible after the accepting edge, done after the second
    drive(32'h10, 32'h4, 32'h23, 1'b0, 1'b1, SZ_WORD, 1'b1, 1'b0);
    tick(1);
    idle();
    checkVal("st_miss_e1_pc", bus.PC_out, 32'h0000_0000);
    tick(1);
    checkVal("st_miss_e2_pc", bus.PC_out, 32'h0000_0010);
    checkVal("st_miss_e2_lw", bus.lwData, 32'h0000_0000);

    drive(32'h14, 32'h8, 32'h46, 1'b0, 1'b1, SZ_WORD, 1'b1, 1'b0);
    tick(1);
    idle();
    tick(1);
    fastOp(32'h18, 32'h4, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("ld4_lw", bus.lwData, 32'h0000_0023);
    checkVal("ld4_pc", bus.PC_out, 32'h0000_0018);
    fastOp(32'h20, 32'h5, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("ld5_lw", bus.lwData, 32'h4600_0000);

    // Miss load; inputs changed during WAIT must be ignored
    drive(32'h1C, 32'h8, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1, 1'b0);
    tick(1);
    checkVal("ldmiss_e1_lw", bus.lwData, 32'h4600_0000);
    checkVal("ldmiss_e1_pc", bus.PC_out, 32'h0000_0020);
    drive(32'h99, 32'h4, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 1'b0);
    tick(1);
    idle();
    checkVal("ldmiss_e2_lw", bus.lwData, 32'h0000_0046);
    checkVal("ldmiss_e2_pc", bus.PC_out, 32'h0000_001C);

    drive(32'h24, 32'h4, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1, 1'b1);
    tick(1);
    idle();
    checkVal("lsq_lw", bus.lwData, 32'h0000_0023);
    checkVal("lsq_pc", bus.PC_out, 32'h0000_0024);

    // Byte store merges into a word; only dataSw[7:0] lands
    fastOp(32'h30, 32'h10, 32'hAABB_CCDD, 1'b0, 1'b1, SZ_WORD);
    fastOp(32'h34, 32'h12, 32'hFFFF_FF11, 1'b0, 1'b1, SZ_BYTE);
    checkVal("st_keeps_lw", bus.lwData, 32'h0000_0023);
    checkVal("stb_pc", bus.PC_out, 32'h0000_0034);
    fastOp(32'h38, 32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("merge_lw", bus.lwData, 32'hAA11_CCDD);

    // Wrap at the top of memory and high address bits
    fastOp(32'h3C, 32'h3FE, 32'h4433_2211, 1'b0, 1'b1, SZ_WORD);
    fastOp(32'h40, 32'h3FE, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("wrap_lw", bus.lwData, 32'h4433_2211);
    fastOp(32'h44, 32'h0, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("wrap_low_lw", bus.lwData, 32'h0000_4433);
    fastOp(32'h48, 32'h404, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("alias_lw", bus.lwData, 32'h0000_0023);

    // Read+write together is a store
    fastOp(32'h4C, 32'h20, 32'h55, 1'b1, 1'b1, SZ_WORD);
    checkVal("rw_lw", bus.lwData, 32'h0000_0023);
    checkVal("rw_pc", bus.PC_out, 32'h0000_004C);
    fastOp(32'h50, 32'h20, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("rw_data", bus.lwData, 32'h0000_0055);

    // Held request repeats harmlessly
    drive(32'h54, 32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 1'b0);
    tick(3);
    idle();
    checkVal("held_lw", bus.lwData, 32'hAA11_CCDD);
    checkVal("held_pc", bus.PC_out, 32'h0000_0054);
    tick(2);
    checkVal("noreq_hold", bus.lwData, 32'hAA11_CCDD);

    // Reset while a miss store is waiting
    drive(32'h60, 32'h30, 32'h77, 1'b0, 1'b1, SZ_WORD, 1'b1, 1'b0);
    tick(1);
    idle();
    rstn = 1'b1;
    #1;
    checkVal("midrst_lw", bus.lwData, 32'h0000_0000);
    checkVal("midrst_pc", bus.PC_out, 32'h0000_0000);
    #1;
    rstn = 1'b0;
    tick(2);
    checkVal("midrst_idle_pc", bus.PC_out, 32'h0000_0000);
    fastOp(32'h64, 32'h30, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("midrst_nowrite", bus.lwData, 32'h0000_0000);
    checkVal("post_rst_pc", bus.PC_out, 32'h0000_0064);
    fastOp(32'h68, 32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD);
    checkVal("mem_cleared", bus.lwData, 32'h0000_0000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
